// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-locked arbiter for the dual-clock FIFO write port
// Define FIFO_ARB_STATS_EN to add per-source beat counters and a stall counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_beats,
  output logic [15:0]                   stat_stall
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                          state, state_nxt;
  logic [ID_WIDTH-1:0]             grant_nxt, rr_ptr, rr_ptr_nxt, winner;
  logic                            any_valid;
  int                              idx;
  logic [NUM_REQ-1:0]              vsh;
  logic [NUM_REQ-1:0]              g_valid_vec, g_last_vec;
  logic [NUM_REQ*DATA_WIDTH-1:0]   g_data_vec;
  logic                            g_valid, g_last;
  logic [DATA_WIDTH-1:0]           g_data;

  // Scanning downward lets the source closest to rr_ptr overwrite the others.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    vsh       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      vsh = req_valid >> idx;
      if (vsh[0]) begin
        any_valid = 1'b1;
        winner    = idx[ID_WIDTH-1:0];
      end
    end
  end

  // Only the registered grant steers the datapath, so idle sources never reach an output.
  assign g_valid_vec = req_valid >> grant_id;
  assign g_last_vec  = req_last >> grant_id;
  assign g_data_vec  = req_data >> (int'(grant_id) * DATA_WIDTH);
  assign g_valid     = g_valid_vec[0];
  assign g_last      = g_last_vec[0];
  assign g_data      = g_data_vec[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    busy       = (state == BURST);
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = BURST;
          grant_nxt = winner;
        end
      end
      BURST: begin
        req_ready  = NUM_REQ'(!fifo_full) << grant_id;
        fifo_wr_en = g_valid & !fifo_full;
        if (fifo_wr_en) begin
          fifo_data = g_data;
          if (g_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat_cnt
    logic [15:0] cnt;
    always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (fifo_wr_en && (int'(grant_id) == i) && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stat_beats[i*16 +: 16] = cnt;
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_stall <= '0;
    end else if (busy && g_valid && fifo_full && (stat_stall != 16'hFFFF)) begin
      stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a queue-based packet model
// Stats checks are compiled only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          wr_clk    = 1'b0;
  logic          rst       = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_last  = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data;
  logic [IW-1:0] grant_id;
  logic          busy;
`ifdef FIFO_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [N*16-1:0] stat_beats;
  logic [15:0]   stat_stall;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_beats (stat_beats),
    .stat_stall (stat_stall)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;
  int expect_total = 0;

  // Per-source packet streams: head index hd, tail index tl.
  logic [W-1:0] bd [N][256];
  bit           bl [N][256];
  int           hd [N];
  int           tl [N];

  // Model: is a packet in flight, which source owns it, who has priority next.
  bit m_busy = 1'b0;
  int m_g = 0;
  int m_ptr = 0;
  bit m_found;

  logic [W-1:0]  wlog [$];
  int            glog [$];
  int            wcyc [$];
  logic [N-1:0]  e_ready;
  bit            e_we;
  logic [W-1:0]  e_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int s, input int d, input bit last);
    bd[s][tl[s] % 256] = W'(d);
    bl[s][tl[s] % 256] = last;
    tl[s]++;
    expect_total++;
  endtask

  task automatic push_pkt(input int s, input int len, input int base);
    for (int k = 0; k < len; k++) push_beat(s, base + k, k == len - 1);
  endtask

  task automatic wait_writes(input int n);
    for (int c = 0; c < 300 && wlog.size() < n; c++) begin
      @(negedge wr_clk);
      #1;
    end
    check("write_timeout", 32'(wlog.size() >= n), 1);
  endtask

  function automatic int pending();
    int p = 0;
    for (int s = 0; s < N; s++) p += tl[s] - hd[s];
    return p;
  endfunction

  // Reference model advances on each edge from the same inputs the DUT sees.
  always @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_g    = 0;
      m_ptr  = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        m_found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && req_valid[(m_ptr + k) % N]) begin
            m_found = 1'b1;
            m_g     = (m_ptr + k) % N;
          end
        end
        m_busy = m_found;
      end else if (req_valid[m_g] && !fifo_full) begin
        if (bl[m_g][hd[m_g] % 256]) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
        end
        hd[m_g]++;
      end
    end
  end

  // Sources present their queue head; non-granted requests stay up once raised.
  always @(posedge wr_clk) begin
    #1;
    for (int s = 0; s < N; s++) begin
      if (hd[s] == tl[s]) req_valid[s] = 1'b0;
      else if (!rand_mode) req_valid[s] = 1'b1;
      else if (m_busy && m_g == s) req_valid[s] = ($urandom_range(3) != 0);
      else req_valid[s] = req_valid[s] | ($urandom_range(1) == 0);
      req_data[s*W +: W] = bd[s][hd[s] % 256];
      req_last[s]        = bl[s][hd[s] % 256];
    end
    if (rand_mode) fifo_full = ($urandom_range(3) == 0);
  end

  always @(negedge wr_clk) begin
    e_we    = m_busy && req_valid[m_g] && !fifo_full;
    e_ready = '0;
    if (m_busy && !fifo_full) e_ready[m_g] = 1'b1;
    e_data  = e_we ? bd[m_g][hd[m_g] % 256] : '0;
    check("busy", 32'(busy), 32'(m_busy));
    check("grant_id", 32'(grant_id), m_g);
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_we));
    check("fifo_data", 32'(fifo_data), 32'(e_data));
    if (fifo_wr_en) begin
      wlog.push_back(fifo_data);
      glog.push_back(int'(grant_id));
      wcyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int s = 0; s < N; s++) push_pkt(s, 1, 'hA0 + s);
    repeat (3) @(negedge wr_clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_grant", 32'(grant_id), 0);
    @(negedge wr_clk);
    rst = 1'b0;

    wait_writes(4);
    for (int i = 0; i < 4; i++) begin
      check("rr_data", 32'(wlog[i]), 'hA0 + i);
      check("rr_order", glog[i], i);
    end
    for (int i = 0; i < 3; i++) check("rr_spacing", wcyc[i+1] - wcyc[i], 2);

    base = wlog.size();
    push_beat(0, 'h11, 1'b0);
    push_beat(0, 'h22, 1'b0);
    push_beat(0, 'h33, 1'b1);
    wait_writes(base + 3);
    check("pkt_b0", 32'(wlog[base]), 'h11);
    check("pkt_b1", 32'(wlog[base+1]), 'h22);
    check("pkt_b2", 32'(wlog[base+2]), 'h33);
    check("pkt_back2back", wcyc[base+2] - wcyc[base], 2);
    @(posedge wr_clk);
    #2;
    check("model_rr_ptr", m_ptr, 1);
    check("pkt_idle", 32'(busy), 0);

    base = wlog.size();
    push_pkt(1, 4, 'h40);
    push_pkt(2, 1, 'h50);
    wait_writes(base + 1);
    @(posedge wr_clk);
    #2;
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge wr_clk);
      #1;
      check("bp_ready", 32'(req_ready), 0);
      check("bp_wr_en", 32'(fifo_wr_en), 0);
      check("bp_grant", 32'(grant_id), 1);
      @(posedge wr_clk);
      #2;
    end
    fifo_full = 1'b0;
    wait_writes(base + 5);
    for (int i = 0; i < 4; i++) check("bp_data", 32'(wlog[base+i]), 'h40 + i);
    check("bp_next_src", glog[base+4], 2);
    check("bp_next_data", 32'(wlog[base+4]), 'h50);

    base = wlog.size();
    push_pkt(2, 3, 'h60);
    wait_writes(base + 1);
    @(posedge wr_clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_wr_en", 32'(fifo_wr_en), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    check("mid_rst_data", 32'(fifo_data), 0);
    for (int s = 0; s < N; s++) begin
      expect_total -= tl[s] - hd[s];
      hd[s] = tl[s];
    end
    push_pkt(0, 1, 'h70);
    push_pkt(3, 1, 'h73);
    repeat (2) @(negedge wr_clk);
    rst = 1'b0;
    wait_writes(base + 3);
    check("mid_rst_first", 32'(wlog[base]), 'h60);
    check("post_rst_winner", glog[base+1], 0);
    check("post_rst_next", 32'(wlog[base+2]), 'h73);

`ifdef FIFO_ARB_STATS_EN
    @(negedge wr_clk);
    stat_clr = 1'b1;
    @(negedge wr_clk);
    stat_clr = 1'b0;
    base = wlog.size();
    push_pkt(2, 5, 'h80);
    wait_writes(base + 1);
    @(posedge wr_clk);
    #2;
    fifo_full = 1'b1;
    repeat (2) begin
      @(posedge wr_clk);
      #2;
    end
    fifo_full = 1'b0;
    wait_writes(base + 5);
    @(posedge wr_clk);
    #2;
    check("stat_beats2", 32'(stat_beats[47:32]), 5);
    check("stat_beats0", 32'(stat_beats[15:0]), 0);
    check("stat_stall", 32'(stat_stall), 2);
    @(negedge wr_clk);
    stat_clr = 1'b1;
    @(negedge wr_clk);
    stat_clr = 1'b0;
    #1;
    for (int s = 0; s < N; s++) check("stat_clr_beats", 32'(stat_beats[s*16 +: 16]), 0);
    check("stat_clr_stall", 32'(stat_stall), 0);
`endif

    for (int s = 0; s < N; s++)
      for (int p = 0; p < 12; p++) push_pkt(s, $urandom_range(5, 1), $urandom_range(255));
    rand_mode = 1'b1;
    for (int c = 0; c < 5000 && pending() != 0; c++) @(negedge wr_clk);
    rand_mode = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge wr_clk);
    check("rand_drained", pending(), 0);
    check("total_writes", wlog.size(), expect_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
